// File: rtl/fsm_input_cond_pkg.sv
// Shared types for the input-conditioning block: the per-bit debounce
// event kind and a helper that classifies a stable-value update.
package fsm_input_cond_pkg;

    // Outcome of one debounce evaluation for a single bit.
    typedef enum logic [1:0] {
        EV_NONE = 2'b00,
        EV_RISE = 2'b01,
        EV_FALL = 2'b10
    } edge_e;

    // Direction of a stable-value update, given the value being adopted.
    function automatic edge_e edge_of(input logic new_val);
        return new_val ? EV_RISE : EV_FALL;
    endfunction

endpackage

// File: rtl/fsm_debounce_bit.sv
// One conditioned input bit: SYNC_STAGES-deep synchronizer, mismatch
// counter, debounced stable bit and registered rise/fall pulses.
// event_o is the combinational "pulse next edge" flag so the parent can
// register an aggregate flag aligned with rise_o/fall_o.
module fsm_debounce_bit
    import fsm_input_cond_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   DEBOUNCE    = 4,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    input  logic hold_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o,
    output logic event_o
);

    localparam int               CNT_W    = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   stable_q, stable_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rise_q, fall_q;
    edge_e                  ev_d;

    assign synced = sync_q[SYNC_STAGES-1];

    // Synchronizer chain: keeps sampling regardless of hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    // Debounce decision: hold clears the count and blocks any update, a match
    // clears the count, and the DEBOUNCE-th consecutive mismatch adopts the
    // synchronized value.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        ev_d     = EV_NONE;
        if (hold_i) begin
            cnt_d = '0;
        end else if (synced == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            stable_d = synced;
            ev_d     = edge_of(synced);
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Stable value, counter and edge pulses; pulses last exactly one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_q <= RST_VAL;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= (ev_d == EV_RISE);
            fall_q   <= (ev_d == EV_FALL);
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign event_o  = (ev_d != EV_NONE);

endmodule

// File: rtl/fsm_input_cond.sv
// Input conditioner for a downstream FSM: synchronizes and debounces INPUTS
// independent raw bits, reporting per-bit rise/fall pulses and a combined
// changed flag that is high in the same cycle as those pulses.
module fsm_input_cond
    import fsm_input_cond_pkg::*;
#(
    parameter int                INPUTS      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter int                DEBOUNCE    = 4,
    parameter logic [INPUTS-1:0] RST_VAL     = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INPUTS-1:0] raw_in,
    input  logic              hold,
    output logic [INPUTS-1:0] in_out,
    output logic [INPUTS-1:0] rise,
    output logic [INPUTS-1:0] fall,
    output logic              changed
);

    logic [INPUTS-1:0] event_d;
    logic              changed_q;

    for (genvar g = 0; g < INPUTS; g++) begin : g_bit
        fsm_debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE    (DEBOUNCE),
            .RST_VAL     (RST_VAL[g])
        ) u_bit (
            .clk      (clk),
            .rst      (rst),
            .raw_i    (raw_in[g]),
            .hold_i   (hold),
            .stable_o (in_out[g]),
            .rise_o   (rise[g]),
            .fall_o   (fall[g]),
            .event_o  (event_d[g])
        );
    end

    // Aggregate change flag, registered from the per-bit pulse-next flags so it
    // lines up with the registered rise/fall pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |event_d;
        end
    end

    assign changed = changed_q;

endmodule

// File: tb/tb_fsm_input_cond.sv
// Bench for fsm_input_cond: a default instance (DEBOUNCE=4) and a fast
// instance (DEBOUNCE=1, RST_VAL=8'h80), checked by directed latency tests and
// by randomized toggling against a per-bit reference model.
module tb_fsm_input_cond;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] raw0, raw1;
    logic       hold0, hold1;
    logic [7:0] in_out0, rise0, fall0, in_out1, rise1, fall1;
    logic       chg0, chg1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fsm_input_cond #(.INPUTS(8), .SYNC_STAGES(2), .DEBOUNCE(4), .RST_VAL(8'h00)) dut0 (
        .clk(clk), .rst(rst_n), .raw_in(raw0), .hold(hold0),
        .in_out(in_out0), .rise(rise0), .fall(fall0), .changed(chg0));

    fsm_input_cond #(.INPUTS(8), .SYNC_STAGES(2), .DEBOUNCE(1), .RST_VAL(8'h80)) dut1 (
        .clk(clk), .rst(rst_n), .raw_in(raw1), .hold(hold1),
        .in_out(in_out1), .rise(rise1), .fall(fall1), .changed(chg1));

    // Reference model: synced is the raw value sampled S edges earlier
    // (RST_VAL until S samples exist since reset); a bit adopts synced after
    // DEBOUNCE consecutive non-hold edges on which it differed.
    logic [7:0] m_in   [2];
    logic [7:0] m_rise [2];
    logic [7:0] m_fall [2];
    logic       m_chg  [2];
    int         ecnt   [2];
    int         run    [2][8];
    logic [7:0] hist   [2][64];

    always @(posedge clk or negedge rst_n) begin
        int         e, deb;
        int         rn [8];
        logic [7:0] r, rv, syn, nin, nr, nf;
        logic       h;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_in[k]   <= (k == 0) ? 8'h00 : 8'h80;
                m_rise[k] <= 8'h00;
                m_fall[k] <= 8'h00;
                m_chg[k]  <= 1'b0;
                ecnt[k]   <= 0;
                for (int b = 0; b < 8; b++) run[k][b] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                r   = (k == 0) ? raw0 : raw1;
                h   = (k == 0) ? hold0 : hold1;
                rv  = (k == 0) ? 8'h00 : 8'h80;
                deb = (k == 0) ? 4 : 1;
                e   = ecnt[k] + 1;
                syn = (e > S) ? hist[k][6'(e - S)] : rv;
                nin = m_in[k];
                nr  = 8'h00;
                nf  = 8'h00;
                for (int b = 0; b < 8; b++) begin
                    rn[b] = run[k][b];
                    if (h || syn[b] == nin[b]) begin
                        rn[b] = 0;
                    end else begin
                        rn[b] = rn[b] + 1;
                        if (rn[b] == deb) begin
                            rn[b]  = 0;
                            nin[b] = syn[b];
                            if (syn[b]) nr[b] = 1'b1;
                            else        nf[b] = 1'b1;
                        end
                    end
                    run[k][b] <= rn[b];
                end
                hist[k][6'(e)] <= r;
                ecnt[k]        <= e;
                m_in[k]        <= nin;
                m_rise[k]      <= nr;
                m_fall[k]      <= nf;
                m_chg[k]       <= |(nr | nf);
            end
        end
    end

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; raw0 = 8'h00; hold0 = 1'b0; raw1 = 8'h80; hold1 = 1'b0;
        settle(3);
        checks++; if (in_out0 !== 8'h00) begin errors++; $display("FAIL reset_in_out0 got %h exp 00", in_out0); end
        checks++; if ((rise0 | fall0) !== 8'h00) begin errors++; $display("FAIL reset_pulse0 got %h exp 00", rise0 | fall0); end
        checks++; if (chg0 !== 1'b0) begin errors++; $display("FAIL reset_changed0 got %b exp 0", chg0); end
        checks++; if (in_out1 !== 8'h80) begin errors++; $display("FAIL reset_in_out1 got %h exp 80", in_out1); end
        checks++; if ((rise1 | fall1) !== 8'h00) begin errors++; $display("FAIL reset_pulse1 got %h exp 00", rise1 | fall1); end
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checks++; if ({chg0, chg1} !== 2'b00) begin errors++; $display("FAIL release_changed cyc %0d got %b exp 00", n, {chg0, chg1}); end
            checks++; if ({in_out0, in_out1} !== 16'h0080) begin errors++; $display("FAIL release_in_out cyc %0d got %h exp 0080", n, {in_out0, in_out1}); end
        end
    endtask

    task automatic test_latency();
        raw0 = 8'h01;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            checks++; if (in_out0 !== ((n >= 6) ? 8'h01 : 8'h00)) begin errors++; $display("FAIL latency_in_out edge %0d got %h exp %h", n, in_out0, (n >= 6) ? 8'h01 : 8'h00); end
            checks++; if (rise0 !== ((n == 6) ? 8'h01 : 8'h00)) begin errors++; $display("FAIL latency_rise edge %0d got %h exp %h", n, rise0, (n == 6) ? 8'h01 : 8'h00); end
            checks++; if (chg0 !== (n == 6)) begin errors++; $display("FAIL latency_changed edge %0d got %b exp %b", n, chg0, n == 6); end
        end
        raw0 = 8'h00;
        settle(10);
    endtask

    task automatic test_glitch();
        raw0 = 8'h08;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 3) raw0 = 8'h00;
            checks++; if (in_out0 !== 8'h00) begin errors++; $display("FAIL glitch_in_out cyc %0d got %h exp 00", n, in_out0); end
            checks++; if ((rise0 | fall0) !== 8'h00) begin errors++; $display("FAIL glitch_pulse cyc %0d got %h exp 00", n, rise0 | fall0); end
        end
    endtask

    task automatic test_hold();
        raw0 = 8'hFF;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 3)  hold0 = 1'b1;
            if (n == 13) hold0 = 1'b0;
            checks++; if (in_out0 !== ((n >= 17) ? 8'hFF : 8'h00)) begin errors++; $display("FAIL hold_in_out edge %0d got %h exp %h", n, in_out0, (n >= 17) ? 8'hFF : 8'h00); end
            checks++; if (rise0 !== ((n == 17) ? 8'hFF : 8'h00)) begin errors++; $display("FAIL hold_rise edge %0d got %h exp %h", n, rise0, (n == 17) ? 8'hFF : 8'h00); end
            checks++; if (chg0 !== (n == 17)) begin errors++; $display("FAIL hold_changed edge %0d got %b exp %b", n, chg0, n == 17); end
        end
        raw0 = 8'h00;
        settle(10);
    endtask

    task automatic test_reset_mid();
        raw0 = 8'h01;
        settle(3);
        rst_n = 1'b0;
        #1;
        checks++; if (in_out0 !== 8'h00) begin errors++; $display("FAIL rstmid_in_out got %h exp 00", in_out0); end
        checks++; if ({rise0, fall0, 7'h0, chg0} !== 16'h0000) begin errors++; $display("FAIL rstmid_pulse got %h exp 0000", {rise0, fall0, 7'h0, chg0}); end
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            checks++; if ({in_out0, rise0, fall0} !== 24'h0) begin errors++; $display("FAIL rstmid_hold cyc %0d got %h exp 000000", n, {in_out0, rise0, fall0}); end
        end
        rst_n = 1'b1;
        for (int m = 1; m <= 8; m++) begin
            @(negedge clk);
            checks++; if (in_out0 !== ((m >= 6) ? 8'h01 : 8'h00)) begin errors++; $display("FAIL rstrel_in_out edge %0d got %h exp %h", m, in_out0, (m >= 6) ? 8'h01 : 8'h00); end
            checks++; if (rise0 !== ((m == 6) ? 8'h01 : 8'h00)) begin errors++; $display("FAIL rstrel_rise edge %0d got %h exp %h", m, rise0, (m == 6) ? 8'h01 : 8'h00); end
            checks++; if (chg1 !== 1'b0) begin errors++; $display("FAIL rstrel_changed1 edge %0d got %b exp 0", m, chg1); end
        end
        raw0 = 8'h00;
        settle(10);
    endtask

    task automatic test_debounce1();
        raw1 = 8'h00;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            checks++; if (in_out1 !== ((n >= 3) ? 8'h00 : 8'h80)) begin errors++; $display("FAIL deb1_in_out edge %0d got %h exp %h", n, in_out1, (n >= 3) ? 8'h00 : 8'h80); end
            checks++; if (fall1 !== ((n == 3) ? 8'h80 : 8'h00)) begin errors++; $display("FAIL deb1_fall edge %0d got %h exp %h", n, fall1, (n == 3) ? 8'h80 : 8'h00); end
            checks++; if (rise1 !== 8'h00) begin errors++; $display("FAIL deb1_rise edge %0d got %h exp 00", n, rise1); end
            checks++; if (chg1 !== (n == 3)) begin errors++; $display("FAIL deb1_changed edge %0d got %b exp %b", n, chg1, n == 3); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            checks++; if ({in_out0, rise0, fall0, chg0} !== {m_in[0], m_rise[0], m_fall[0], m_chg[0]}) begin
                errors++; $display("FAIL rand_dut0 cyc %0d got %h/%h/%h/%b exp %h/%h/%h/%b", n, in_out0, rise0, fall0, chg0, m_in[0], m_rise[0], m_fall[0], m_chg[0]); end
            checks++; if ({in_out1, rise1, fall1, chg1} !== {m_in[1], m_rise[1], m_fall[1], m_chg[1]}) begin
                errors++; $display("FAIL rand_dut1 cyc %0d got %h/%h/%h/%b exp %h/%h/%h/%b", n, in_out1, rise1, fall1, chg1, m_in[1], m_rise[1], m_fall[1], m_chg[1]); end
            checks++; if (((rise0 & fall0) | (rise1 & fall1)) !== 8'h00) begin
                errors++; $display("FAIL rand_rise_and_fall cyc %0d got %h exp 00", n, (rise0 & fall0) | (rise1 & fall1)); end
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 7) == 0) raw0[b] = ~raw0[b];
                if ($urandom_range(0, 5) == 0) raw1[b] = ~raw1[b];
            end
            if ($urandom_range(0, 15) == 0) hold0 = ~hold0;
            if ($urandom_range(0, 15) == 0) hold1 = ~hold1;
            if (n < 40) begin
                hold0 = 1'b0;
                if (n % 8 == 0) raw0 = ~raw0;
            end
        end
        hold0 = 1'b0;
        hold1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_hold();
        test_reset_mid();
        test_debounce1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
